// File: rtl/clk_gen_pkg.sv
// Shared constants and phase-length helpers for the clk_gen divided-clock generator.
package clk_gen_pkg;

  localparam int unsigned MIN_PERIOD = 2;

  function automatic int unsigned calc_high(input int unsigned p);
    return p - (p / 2);
  endfunction

  function automatic int unsigned calc_low(input int unsigned p);
    return p / 2;
  endfunction

  // Periods below two cannot hold a high and a low phase, so they are raised to MIN_PERIOD.
  function automatic int unsigned clamp_period(input int unsigned p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

endpackage

// File: rtl/clk_gen.sv
// Divided clock generator: clk_o has a period of P clk_i cycles (H high, L low) with edge strobes.
// Runtime period reload is included only when CLK_GEN_RUNTIME_PERIOD_EN is defined.
module clk_gen
  import clk_gen_pkg::*;
#(
  parameter int CLK_PERIOD = 4,
  parameter int PERIOD_W   = 16
) (
  input  logic                clk_i,
  input  logic                rst_n,
  input  logic                en_i,
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
  input  logic [PERIOD_W-1:0] period_i,
  input  logic                period_valid_i,
`endif
  output logic                clk_o,
  output logic                rise_o,
  output logic                fall_o
);

  generate
    if ((longint'(CLK_PERIOD) < longint'(MIN_PERIOD)) ||
        (longint'(CLK_PERIOD) > ((longint'(1) << PERIOD_W) - 1))) begin : g_bad_period
      $error("clk_gen: CLK_PERIOD out of range");
    end
  endgenerate

  localparam logic [PERIOD_W-1:0] RESET_PERIOD = PERIOD_W'(CLK_PERIOD);
  localparam logic [PERIOD_W-1:0] PH_ONE       = PERIOD_W'(1);

  logic [PERIOD_W-1:0] ph_reg;
  logic [PERIOD_W-1:0] ph_next;
  logic                clk_next;
  logic                rise_next;
  logic                fall_next;
  logic [PERIOD_W-1:0] active_period;
  logic [PERIOD_W-1:0] rise_period;

`ifdef CLK_GEN_RUNTIME_PERIOD_EN
  logic [PERIOD_W-1:0] period_reg;
  logic [PERIOD_W-1:0] period_next;
  logic [PERIOD_W-1:0] pend_reg;
  logic [PERIOD_W-1:0] pend_next;
  logic                pend_flag_reg;
  logic                pend_flag_next;

  assign active_period = period_reg;
  assign rise_period   = pend_flag_reg ? pend_reg : period_reg;
`else
  assign active_period = RESET_PERIOD;
  assign rise_period   = RESET_PERIOD;
`endif

  always_comb begin
    ph_next   = ph_reg;
    clk_next  = clk_o;
    rise_next = 1'b0;
    fall_next = 1'b0;
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
    period_next    = period_reg;
    pend_next      = pend_reg;
    pend_flag_next = pend_flag_reg;
`endif
    if (!en_i) begin
      clk_next  = 1'b0;
      ph_next   = '0;
      fall_next = clk_o;
    end else if (ph_reg == '0) begin
      if (!clk_o) begin
        clk_next  = 1'b1;
        rise_next = 1'b1;
        ph_next   = PERIOD_W'(calc_high(32'(rise_period)) - 1);
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
        period_next    = rise_period;
        pend_flag_next = 1'b0;
`endif
      end else begin
        clk_next  = 1'b0;
        fall_next = 1'b1;
        ph_next   = PERIOD_W'(calc_low(32'(active_period)) - 1);
      end
    end else begin
      ph_next = ph_reg - PH_ONE;
    end
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
    // Captured after the adoption above so a strobe on a rising toggle waits for the next rise.
    if (period_valid_i) begin
      pend_next      = PERIOD_W'(clamp_period(32'(period_i)));
      pend_flag_next = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      ph_reg <= '0;
      clk_o  <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
      period_reg    <= RESET_PERIOD;
      pend_reg      <= RESET_PERIOD;
      pend_flag_reg <= 1'b0;
`endif
    end else begin
      ph_reg <= ph_next;
      clk_o  <= clk_next;
      rise_o <= rise_next;
      fall_o <= fall_next;
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
      period_reg    <= period_next;
      pend_reg      <= pend_next;
      pend_flag_reg <= pend_flag_next;
`endif
    end
  end

endmodule

// File: tb/tb_clk_gen.sv
// Self-checking bench for clk_gen: vector table on a P=4 instance, generated sequence on a P=5 instance.
module tb_clk_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, rst5_n, en5;
  logic c4, r4, f4, c5, r5, f5;
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
  logic [15:0] pi;
  logic        pv;
`endif

  clk_gen #(.CLK_PERIOD(4), .PERIOD_W(16)) dut4 (
    .clk_i(clk), .rst_n(rst_n), .en_i(en),
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
    .period_i(pi), .period_valid_i(pv),
`endif
    .clk_o(c4), .rise_o(r4), .fall_o(f4)
  );

  clk_gen #(.CLK_PERIOD(5), .PERIOD_W(16)) dut5 (
    .clk_i(clk), .rst_n(rst5_n), .en_i(en5),
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
    .period_i(16'd0), .period_valid_i(1'b0),
`endif
    .clk_o(c5), .rise_o(r5), .fall_o(f5)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        pv;
    logic [15:0] pi;
    logic [2:0]  exp;  // {clk_o, rise_o, fall_o}
  } vec_t;

  vec_t       tbl[$];
  logic [2:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic v,
                              input int p, input logic [2:0] x);
    vec_t t;
    t.rst_n = r; t.en = e; t.pv = v; t.pi = 16'(p); t.exp = x;
    return t;
  endfunction

  task automatic step4(input vec_t v, input int idx);
    logic [2:0] got, want;
    rst_n = v.rst_n;
    en    = v.en;
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
    pv = v.pv;
    pi = v.pi;
`endif
    exp_q.push_back(v.exp);
    @(posedge clk); #1;
    got  = {c4, r4, f4};
    want = exp_q.pop_front();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL p4_vec%0d clk/rise/fall got=%b want=%b", idx, got, want);
    end else
      $display("ok   p4_vec%0d rst_n=%b en=%b clk/rise/fall=%b", idx, v.rst_n, v.en, got);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int rises;
    logic [2:0] got5, want5;
    rst_n = 1'b0; en = 1'b0; rst5_n = 1'b0; en5 = 1'b0;
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
    pv = 1'b0; pi = 16'd0;
`endif
    // P=4: reset, steady run, enable drop while high, re-enable, mid-high reset
    tbl.push_back(mk(0,0,0,0,3'b000));
    tbl.push_back(mk(0,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b100));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b100));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,0,0,0,3'b001));
    tbl.push_back(mk(1,0,0,0,3'b000));
    tbl.push_back(mk(1,0,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b100));
    tbl.push_back(mk(0,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b100));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
`ifdef CLK_GEN_RUNTIME_PERIOD_EN
    // Strobe 6 mid-high: current period completes 2/2, then 3/3
    tbl.push_back(mk(0,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,1,1,6,3'b100));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b100));
    tbl.push_back(mk(1,1,0,0,3'b100));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b000));
    // Strobe 1 on a rising toggle: not adopted until the following rise, clamped to 2
    tbl.push_back(mk(1,1,1,1,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b100));
    tbl.push_back(mk(1,1,0,0,3'b100));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,1,0,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,0,0,3'b110));
    // Pending 6 discarded by reset: period returns to 4
    tbl.push_back(mk(1,1,1,6,3'b001));
    tbl.push_back(mk(0,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
    tbl.push_back(mk(1,1,0,0,3'b100));
    tbl.push_back(mk(1,1,0,0,3'b001));
    tbl.push_back(mk(1,1,0,0,3'b000));
    tbl.push_back(mk(1,1,0,0,3'b110));
`endif
    for (int i = 0; i < tbl.size(); i++) step4(tbl[i], i);

    // P=5: 3 high / 2 low, 10 rises over 50 enabled cycles
    rst_n = 1'b0; en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst5_n = 1'b1; en5 = 1'b1;
    rises = 0;
    for (int k = 0; k < 50; k++) begin
      exp_q.push_back({(k % 5) < 3, (k % 5) == 0, (k % 5) == 3});
      @(posedge clk); #1;
      got5  = {c5, r5, f5};
      want5 = exp_q.pop_front();
      if (r5) rises++;
      checks++;
      if (got5 !== want5) begin
        errors++;
        $display("FAIL p5_cyc%0d clk/rise/fall got=%b want=%b", k, got5, want5);
      end else
        $display("ok   p5_cyc%0d clk/rise/fall=%b", k, got5);
    end
    checks++;
    if (rises != 10) begin
      errors++;
      $display("FAIL p5_rise_count got=%0d want=10", rises);
    end else
      $display("ok   p5_rise_count=%0d", rises);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
